multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Parametrised multicycle control unit for the MIPS-style datapath. It sequences fetch, decode, execute, memory and writeback per opcode class, and drives every datapath enable and mux select. Over the previous control generation it adds:
- a memory wait-state handshake;
- a global stall;
- an illegal-opcode trap state;
- explicit per-state defaults for every output;
- a retired-instruction counter.

Parameters:
- OP_W, 4, opcode width; opcode taken from the OP_W-1..OP_W-4 MSBs, extra low bits must be zero, else illegal.
- ALUSRCB_W, 3, width of alu_src_b select.
- CNT_W, 16, width of retire_cnt.
- MEM_WAIT, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- op  in  OP_W  opcode from instruction register; valid from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- stall  in  1  freeze sequencing.
- pc_src  out  2  00 ALU, 01 branch target, 10 trap vector.
- iord  out  1  0 PC address, 1 ALU-out address.
- mem_read, mem_write, ir_write, pc_write, reg_write  out  1 each  enables.
- reg_dst, reg_src_a, alu_src_a, mem_to_reg  out  1 each  mux selects.
- alu_src_b  out  ALUSRCB_W  000 regB, 001 const 1, 010 jump offset, 011 upper imm, 100 sign-ext imm.
- alu_dir  out  2  00 add, 10 funct-directed.
- branch, be  out  1 each  branch enable; be = 1 for equal (op 0100), 0 for not-equal (op 0101).
- illegal  out  1  high in TRAP.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- retire_cnt  out  CNT_W  retired instruction count.
- state_o  out  4  current state code.

Behaviour:
Output rules:
- Outputs are decoded combinationally from the state register, plus mem_ready and stall where stated.
- Every output has default 0 in every state; only the listed signals are driven high.
- Reset: state = FETCH on the next edge, retire_cnt = 0, all outputs at FETCH values.

State codes and next-state transitions:
- FETCH (0): stays in FETCH until mem_ready, then goes to DECODE.
- DECODE (1), on op:
  - R-type 1000/1100/1011/1111 -> EXEC_R.
  - I-ALU 1001/1010/1101/1110/0111/0110 -> EXEC_I.
  - 0000 -> EXEC_IU.
  - lw 0001 / sw 0010 -> EXEC_ADDR.
  - 0100/0101 -> EXEC_B.
  - 0011 -> EXEC_J.
  - Any other op, or nonzero extra low bits -> TRAP.
- EXEC_R (2), EXEC_I (3), EXEC_IU (4) -> WB_ALU (10).
- EXEC_ADDR (5) -> MEM_RD (7) if op = 0001, else MEM_WR (8).
- EXEC_B (6), EXEC_J (9), TRAP (12) -> FETCH.
- MEM_RD: stays until mem_ready, then goes to WB_MEM (11).
- MEM_WR: stays until mem_ready, then goes to FETCH.
- WB_ALU, WB_MEM -> FETCH.

Active outputs per state (all others 0):
- FETCH: mem_read=1, alu_src_b=001.
  - pc_write and ir_write assert only in the cycle where mem_ready=1.
- DECODE: none; lw/sw classes set reg_dst=1, reg_src_a=1.
- EXEC_R: alu_src_a=1, alu_dir=10.
- EXEC_I: alu_src_a=1, alu_src_b=100, alu_dir=10.
- EXEC_IU: alu_src_a=1, alu_src_b=011, alu_dir=10.
- EXEC_ADDR: alu_src_a=1, alu_src_b=100.
- EXEC_B: pc_src=01, branch=1, be per op.
- EXEC_J: pc_write=1, alu_src_b=010.
- MEM_RD: iord=1, mem_read=1.
- MEM_WR: iord=1, mem_write=1 (held high while waiting).
- WB_ALU: reg_write=1.
- WB_MEM: reg_write=1, reg_dst=1, mem_to_reg=1.
- TRAP: illegal=1, pc_src=10, pc_write=1.

instr_done and retire_cnt:
- instr_done=1 in WB_ALU, WB_MEM, EXEC_B, EXEC_J, TRAP, and in MEM_WR when mem_ready=1.
- retire_cnt increments on every instr_done edge, including TRAP.
- retire_cnt wraps modulo 2^CNT_W.

Stall:
- While stall=1 the state holds and retire_cnt holds.
- pc_write, ir_write, reg_write, mem_write and instr_done are forced to 0; other outputs are unchanged.
- stall has priority over mem_ready; a completion is taken only when stall=0.

Latency with mem_ready=1:
- R/I: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- branch/jump/trap: 3 cycles.
- Each wait cycle with mem_ready=0 adds 1 cycle.

Boundaries:
- Reset beats stall.
- Reset asserted mid-instruction gives FETCH on the next edge, with no write enable in that cycle.
- MEM_WAIT=0 gives the minimum latencies regardless of mem_ready.

Test Plan:
- Reset, then op=1000 with mem_ready=1 -> state_o sequence 0,1,2,10,0; reg_write=1 only in state 10; retire_cnt 0->1.
- op=0001 with mem_ready low for 2 cycles in MEM_RD -> sequence 0,1,5,7,7,7,11,0; iord=1 in state 7; mem_to_reg=1 in state 11.
- op=0010 with mem_ready low 1 cycle in MEM_WR -> mem_write high 2 cycles; instr_done only in the second.
- op=0101 -> state 6 with branch=1, be=0, pc_src=01; op=0100 -> be=1.
- op=0011 -> state 9 with pc_write=1, alu_src_b=010; undefined op (e.g. OP_W=5 with low bit 1) -> TRAP: illegal=1, pc_src=10, pc_write=1, retire_cnt increments.
- stall=1 for 3 cycles in WB_ALU -> state holds, reg_write=0, retire_cnt frozen.
- Reset pulsed in EXEC_ADDR -> FETCH next cycle, retire_cnt=0.
- With CNT_W=2, 5 instructions retired -> retire_cnt=1.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control unit for a MIPS-style datapath: sequences fetch/decode/execute/memory/
// writeback, drives all datapath enables and selects, and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter int unsigned OP_W      = 4,
  parameter int unsigned ALUSRCB_W = 3,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MEM_WAIT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      op,
  input  logic                 mem_ready,
  input  logic                 stall,
  output logic [1:0]           pc_src,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 reg_src_a,
  output logic                 alu_src_a,
  output logic                 mem_to_reg,
  output logic [ALUSRCB_W-1:0] alu_src_b,
  output logic [1:0]           alu_dir,
  output logic                 branch,
  output logic                 be,
  output logic                 illegal,
  output logic                 instr_done,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StExecR    = 4'd2,
    StExecI    = 4'd3,
    StExecIu   = 4'd4,
    StExecAddr = 4'd5,
    StExecB    = 4'd6,
    StMemRd    = 4'd7,
    StMemWr    = 4'd8,
    StExecJ    = 4'd9,
    StWbAlu    = 4'd10,
    StWbMem    = 4'd11,
    StTrap     = 4'd12
  } state_e;

  localparam logic [OP_W-1:0] LowMask = OP_W'((64'd1 << (OP_W - 4)) - 64'd1);

  localparam logic [ALUSRCB_W-1:0] SrcBRegB  = ALUSRCB_W'(3'b000);
  localparam logic [ALUSRCB_W-1:0] SrcBOne   = ALUSRCB_W'(3'b001);
  localparam logic [ALUSRCB_W-1:0] SrcBJump  = ALUSRCB_W'(3'b010);
  localparam logic [ALUSRCB_W-1:0] SrcBUpper = ALUSRCB_W'(3'b011);
  localparam logic [ALUSRCB_W-1:0] SrcBSext  = ALUSRCB_W'(3'b100);

  state_e           state_q, state_d;
  state_e           decode_st;
  logic [3:0]       op_class;
  logic             extra_nz;
  logic             ready_eff;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign op_class  = op[OP_W-1 -: 4];
  assign extra_nz  = |(op & LowMask);
  assign ready_eff = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  // Opcode class decode; nonzero extra low bits always trap.
  always_comb begin
    decode_st = StTrap;
    if (!extra_nz) begin
      case (op_class)
        4'b1000, 4'b1100, 4'b1011, 4'b1111:                   decode_st = StExecR;
        4'b1001, 4'b1010, 4'b1101, 4'b1110, 4'b0111, 4'b0110: decode_st = StExecI;
        4'b0000:                                              decode_st = StExecIu;
        4'b0001, 4'b0010:                                     decode_st = StExecAddr;
        4'b0100, 4'b0101:                                     decode_st = StExecB;
        4'b0011:                                              decode_st = StExecJ;
        default:                                              decode_st = StTrap;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:    if (ready_eff) state_d = StDecode;
      StDecode:   state_d = decode_st;
      StExecR,
      StExecI,
      StExecIu:   state_d = StWbAlu;
      StExecAddr: state_d = (op_class == 4'b0001) ? StMemRd : StMemWr;
      StExecB,
      StExecJ,
      StTrap:     state_d = StFetch;
      StMemRd:    if (ready_eff) state_d = StWbMem;
      StMemWr:    if (ready_eff) state_d = StFetch;
      StWbAlu,
      StWbMem:    state_d = StFetch;
      default:    state_d = StFetch;
    endcase
    if (stall) state_d = state_q;
  end

  always_comb begin
    pc_src     = 2'b00;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    reg_src_a  = 1'b0;
    alu_src_a  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = SrcBRegB;
    alu_dir    = 2'b00;
    branch     = 1'b0;
    be         = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SrcBOne;
        pc_write  = ready_eff;
        ir_write  = ready_eff;
      end
      StDecode: begin
        if (!extra_nz && (op_class == 4'b0001 || op_class == 4'b0010)) begin
          reg_dst   = 1'b1;
          reg_src_a = 1'b1;
        end
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_dir   = 2'b10;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBSext;
        alu_dir   = 2'b10;
      end
      StExecIu: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBUpper;
        alu_dir   = 2'b10;
      end
      StExecAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBSext;
      end
      StExecB: begin
        pc_src     = 2'b01;
        branch     = 1'b1;
        be         = (op_class == 4'b0100);
        instr_done = 1'b1;
      end
      StExecJ: begin
        pc_write   = 1'b1;
        alu_src_b  = SrcBJump;
        instr_done = 1'b1;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      StMemWr: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = ready_eff;
      end
      StWbAlu: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      StWbMem: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      StTrap: begin
        illegal    = 1'b1;
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Stall (or an in-flight reset) must not commit any architectural write.
    if (stall || reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (instr_done) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: main instance with a 5-bit opcode field, plus a
// CNT_W=2 / MEM_WAIT=0 instance for counter wrap and minimum-latency checks.
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  logic       reset_a, reset_b, mem_ready, stall;
  logic [4:0] op_a;
  logic [3:0] op_b;

  logic [1:0]  pc_src, alu_dir;
  logic        iord, mem_read, mem_write, ir_write, pc_write, reg_write;
  logic        reg_dst, reg_src_a, alu_src_a, mem_to_reg, branch, be, illegal, instr_done;
  logic [2:0]  alu_src_b;
  logic [15:0] retire_cnt;
  logic [3:0]  state_o;

  logic [1:0] pc_src_b, alu_dir_b;
  logic       iord_b, mem_read_b, mem_write_b, ir_write_b, pc_write_b, reg_write_b;
  logic       reg_dst_b, reg_src_a_b, alu_src_a_b, mem_to_reg_b, branch_b, be_b;
  logic       illegal_b, instr_done_b;
  logic [2:0] alu_src_b_b;
  logic [1:0] retire_cnt_b;
  logic [3:0] state_o_b;

  multicycle_ctrl_fsm #(.OP_W(5), .ALUSRCB_W(3), .CNT_W(16), .MEM_WAIT(1)) dut (
    .clk(clk), .reset(reset_a), .op(op_a), .mem_ready(mem_ready), .stall(stall),
    .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .reg_src_a(reg_src_a), .alu_src_a(alu_src_a), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .alu_dir(alu_dir), .branch(branch), .be(be), .illegal(illegal),
    .instr_done(instr_done), .retire_cnt(retire_cnt), .state_o(state_o)
  );

  multicycle_ctrl_fsm #(.OP_W(4), .ALUSRCB_W(3), .CNT_W(2), .MEM_WAIT(0)) dut_b (
    .clk(clk), .reset(reset_b), .op(op_b), .mem_ready(mem_ready), .stall(stall),
    .pc_src(pc_src_b), .iord(iord_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .ir_write(ir_write_b), .pc_write(pc_write_b), .reg_write(reg_write_b),
    .reg_dst(reg_dst_b), .reg_src_a(reg_src_a_b), .alu_src_a(alu_src_a_b),
    .mem_to_reg(mem_to_reg_b), .alu_src_b(alu_src_b_b), .alu_dir(alu_dir_b),
    .branch(branch_b), .be(be_b), .illegal(illegal_b), .instr_done(instr_done_b),
    .retire_cnt(retire_cnt_b), .state_o(state_o_b)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1; stall = 1'b0; mem_ready = 1'b0;
    op_a = 5'b0; op_b = 4'b0;
    tick(); tick();
    reset_a = 1'b0; reset_b = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state_o);
    end
    checks++;
    if (retire_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", retire_cnt);
    end
    checks++;
    if (mem_read !== 1'b1 || alu_src_b !== 3'b001 || pc_write !== 1'b0 || ir_write !== 1'b0
        || illegal !== 1'b0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait_outputs: got mr=%b srcb=%b pcw=%b irw=%b ill=%b rw=%b expected 1 001 0 0 0 0",
               mem_read, alu_src_b, pc_write, ir_write, illegal, reg_write);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (pc_write !== 1'b1 || ir_write !== 1'b1) begin
      errors++; $display("FAIL fetch_ready_writes: got pcw=%b irw=%b expected 1 1", pc_write, ir_write);
    end
  endtask

  task automatic test_rtype();
    int seq [5] = '{0, 1, 2, 10, 0};
    op_a = {4'b1000, 1'b0}; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state_o !== 4'(seq[i]) || reg_write !== (seq[i] == 10)) begin
        errors++;
        $display("FAIL rtype_step%0d: got state=%0d rw=%b expected state=%0d rw=%b",
                 i, state_o, reg_write, seq[i], (seq[i] == 10));
      end
      if (i == 2) begin
        checks++;
        if (alu_src_a !== 1'b1 || alu_dir !== 2'b10) begin
          errors++; $display("FAIL rtype_exec: got srca=%b dir=%b expected 1 10", alu_src_a, alu_dir);
        end
      end
      if (i < 4) tick();
    end
    exp_cnt++;
    checks++;
    if (retire_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL rtype_cnt: got %0d expected %0d", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_lw_wait();
    int   seq [8] = '{0, 1, 5, 7, 7, 7, 11, 0};
    logic mr  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    op_a = {4'b0001, 1'b0};
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      checks++;
      if (state_o !== 4'(seq[i]) || iord !== (seq[i] == 7) || mem_to_reg !== (seq[i] == 11)) begin
        errors++;
        $display("FAIL lw_step%0d: got state=%0d iord=%b m2r=%b expected state=%0d iord=%b m2r=%b",
                 i, state_o, iord, mem_to_reg, seq[i], (seq[i] == 7), (seq[i] == 11));
      end
      if (i == 1) begin
        checks++;
        if (reg_dst !== 1'b1 || reg_src_a !== 1'b1) begin
          errors++; $display("FAIL lw_decode: got rdst=%b rsa=%b expected 1 1", reg_dst, reg_src_a);
        end
      end
      if (i < 7) tick();
    end
    exp_cnt++;
    checks++;
    if (retire_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL lw_cnt: got %0d expected %0d", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_sw_wait();
    int   seq [6] = '{0, 1, 5, 8, 8, 0};
    logic mr  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    op_a = {4'b0010, 1'b0};
    for (int i = 0; i < 6; i++) begin
      mem_ready = mr[i];
      #1;
      checks++;
      if (state_o !== 4'(seq[i]) || mem_write !== (seq[i] == 8) || instr_done !== (i == 4)) begin
        errors++;
        $display("FAIL sw_step%0d: got state=%0d mw=%b done=%b expected state=%0d mw=%b done=%b",
                 i, state_o, mem_write, instr_done, seq[i], (seq[i] == 8), (i == 4));
      end
      if (i < 5) tick();
    end
    exp_cnt++;
    checks++;
    if (retire_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL sw_cnt: got %0d expected %0d", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_branch();
    int seq [4] = '{0, 1, 6, 0};
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      op_a = {(k == 0) ? 4'b0101 : 4'b0100, 1'b0};
      for (int i = 0; i < 4; i++) begin
        #1;
        checks++;
        if (state_o !== 4'(seq[i])) begin
          errors++; $display("FAIL br%0d_step%0d: got %0d expected %0d", k, i, state_o, seq[i]);
        end
        if (i == 2) begin
          checks++;
          if (branch !== 1'b1 || be !== (k == 1) || pc_src !== 2'b01 || instr_done !== 1'b1) begin
            errors++;
            $display("FAIL br%0d_outputs: got br=%b be=%b pcsrc=%b done=%b expected 1 %b 01 1",
                     k, branch, be, pc_src, instr_done, (k == 1));
          end
        end
        if (i < 3) tick();
      end
      exp_cnt++;
    end
    checks++;
    if (retire_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL br_cnt: got %0d expected %0d", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_jump_trap();
    int seq_j [4] = '{0, 1, 9, 0};
    int seq_t [4] = '{0, 1, 12, 0};
    op_a = {4'b0011, 1'b0};
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state_o !== 4'(seq_j[i])) begin
        errors++; $display("FAIL jump_step%0d: got %0d expected %0d", i, state_o, seq_j[i]);
      end
      if (i == 2) begin
        checks++;
        if (pc_write !== 1'b1 || alu_src_b !== 3'b010) begin
          errors++; $display("FAIL jump_outputs: got pcw=%b srcb=%b expected 1 010", pc_write, alu_src_b);
        end
      end
      if (i < 3) tick();
    end
    exp_cnt++;
    op_a = {4'b1000, 1'b1};
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (state_o !== 4'(seq_t[i])) begin
        errors++; $display("FAIL trap_step%0d: got %0d expected %0d", i, state_o, seq_t[i]);
      end
      if (i == 2) begin
        checks++;
        if (illegal !== 1'b1 || pc_src !== 2'b10 || pc_write !== 1'b1) begin
          errors++; $display("FAIL trap_outputs: got ill=%b pcsrc=%b pcw=%b expected 1 10 1",
                             illegal, pc_src, pc_write);
        end
      end
      if (i < 3) tick();
    end
    exp_cnt++;
    checks++;
    if (retire_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL trap_cnt: got %0d expected %0d", retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall();
    int seq [3] = '{0, 1, 3};
    op_a = {4'b1001, 1'b0}; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state_o !== 4'(seq[i])) begin
        errors++; $display("FAIL stall_pre%0d: got %0d expected %0d", i, state_o, seq[i]);
      end
      if (i == 2) begin
        checks++;
        if (alu_src_b !== 3'b100) begin
          errors++; $display("FAIL exec_i_srcb: got %b expected 100", alu_src_b);
        end
      end
      tick();
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state_o !== 4'd10 || reg_write !== 1'b0 || instr_done !== 1'b0
          || retire_cnt !== 16'(exp_cnt)) begin
        errors++;
        $display("FAIL stall_hold%0d: got state=%0d rw=%b done=%b cnt=%0d expected 10 0 0 %0d",
                 i, state_o, reg_write, instr_done, retire_cnt, exp_cnt);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++;
    if (state_o !== 4'd10 || reg_write !== 1'b1) begin
      errors++; $display("FAIL stall_release: got state=%0d rw=%b expected 10 1", state_o, reg_write);
    end
    tick();
    exp_cnt++;
    #1;
    checks++;
    if (state_o !== 4'd0 || retire_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL stall_done: got state=%0d cnt=%0d expected 0 %0d",
                         state_o, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    op_a = {4'b0001, 1'b0}; mem_ready = 1'b1;
    tick(); tick();
    #1;
    checks++;
    if (state_o !== 4'd5) begin
      errors++; $display("FAIL rst_mid_pre: got %0d expected 5", state_o);
    end
    reset_a = 1'b1; stall = 1'b1;
    tick();
    reset_a = 1'b0; stall = 1'b0;
    exp_cnt = 0;
    #1;
    checks++;
    if (state_o !== 4'd0 || retire_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_mid: got state=%0d cnt=%0d expected 0 0", state_o, retire_cnt);
    end
  endtask

  task automatic test_wrap_nowait();
    reset_b = 1'b1; op_b = 4'b0011; mem_ready = 1'b0;
    tick();
    reset_b = 1'b0;
    #1;
    checks++;
    if (state_o_b !== 4'd0 || retire_cnt_b !== 2'd0) begin
      errors++; $display("FAIL b_reset: got state=%0d cnt=%0d expected 0 0", state_o_b, retire_cnt_b);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (state_o_b !== 4'd0 || retire_cnt_b !== 2'd1) begin
      errors++; $display("FAIL b_min_latency: got state=%0d cnt=%0d expected 0 1",
                         state_o_b, retire_cnt_b);
    end
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (retire_cnt_b !== 2'd0) begin
      errors++; $display("FAIL b_wrap4: got %0d expected 0", retire_cnt_b);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (state_o_b !== 4'd0 || retire_cnt_b !== 2'd1) begin
      errors++; $display("FAIL b_wrap5: got state=%0d cnt=%0d expected 0 1", state_o_b, retire_cnt_b);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_wait();
    test_branch();
    test_jump_trap();
    test_stall();
    test_reset_mid();
    test_wrap_nowait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
